// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with runtime parity/stop config and error flags.
module uart_rx_cfg #(
  parameter int DBITS       = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic             sample_tick,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  output logic [DBITS-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             break_det,
  output logic             busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DBITS + 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DBITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} state_t;
  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_armed;
  logic [TW-1:0]          r_tick;
  logic [BW-1:0]          r_bit;
  logic [DBITS-1:0]       r_shift;
  logic                   r_pxor;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_par_zero;
  logic                   r_stop1_low;
  logic [1:0]             r_par_mode;
  logic                   r_stop2;
  logic                   w_rx_s;
  logic                   w_mid;
  logic                   w_end;
  assign w_rx_s = r_sync[SYNC_STAGES-1];
  assign w_mid  = sample_tick && (r_tick == T_HALF);
  assign w_end  = sample_tick && (r_tick == T_FULL);
  assign busy   = (r_state != IDLE);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sync      <= '1;
      r_armed     <= 1'b0;
      r_tick      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_pxor      <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_par_zero  <= 1'b1;
      r_stop1_low <= 1'b0;
      r_par_mode  <= 2'b00;
      r_stop2     <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], rx};
      data_valid <= 1'b0;
      if (sample_tick) r_tick <= r_tick + TW'(1);
      case (r_state)
        IDLE: begin
          // armed only after a high line, so a held break cannot retrigger
          if (r_armed && !w_rx_s) begin
            r_state    <= START;
            r_tick     <= '0;
            r_armed    <= 1'b0;
            r_par_mode <= cfg_parity;
            r_stop2    <= cfg_stop2;
          end else if (w_rx_s) r_armed <= 1'b1;
        end
        START: if (w_mid) begin
          r_tick     <= '0;
          r_state    <= w_rx_s ? IDLE : DATA;
          r_bit      <= '0;
          r_pxor     <= 1'b0;
          r_perr     <= 1'b0;
          r_ferr     <= 1'b0;
          r_par_zero <= 1'b1;
        end
        DATA: if (w_end) begin
          r_shift <= {w_rx_s, r_shift[DBITS-1:1]};
          r_pxor  <= r_pxor ^ w_rx_s;
          r_bit   <= r_bit + BW'(1);
          if (r_bit == B_LAST) begin
            r_tick  <= '0;
            r_state <= (^r_par_mode) ? PARITY : STOP;
          end
        end
        PARITY: if (w_end) begin
          r_perr     <= r_pxor ^ w_rx_s ^ r_par_mode[1];
          r_par_zero <= !w_rx_s;
          r_tick     <= '0;
          r_state    <= STOP;
        end
        STOP, STOP2: if (w_end) begin
          r_tick <= '0;
          if (r_state == STOP && r_stop2) begin
            r_ferr      <= !w_rx_s;
            r_stop1_low <= !w_rx_s;
            r_state     <= STOP2;
          end else begin
            // complete at mid stop bit so back-to-back frames can resync
            data_out   <= r_shift;
            data_valid <= 1'b1;
            parity_err <= r_perr;
            frame_err  <= r_ferr | !w_rx_s;
            break_det  <= (r_shift == '0) && r_par_zero &&
                          (r_state == STOP ? !w_rx_s : r_stop1_low);
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed bench for uart_rx_cfg (OVERSAMPLE=16, DBITS=8, tick every clk).
module tb_uart_rx_cfg;
  logic       clk = 0;
  logic       reset = 1;
  logic       rx = 1;
  logic       sample_tick = 1;
  logic [1:0] cfg_parity = 2'b00;
  logic       cfg_stop2 = 0;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err, break_det, busy;
  int n_vec = 0, n_err = 0, n_valid = 0, cyc = 0, valid_cyc = 0, t0 = 0, nv0 = 0;
  logic [7:0] cap_d[$];
  logic       cap_f[$];

  uart_rx_cfg #(.DBITS(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .rx(rx), .sample_tick(sample_tick),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .data_out(data_out),
    .data_valid(data_valid), .parity_err(parity_err), .frame_err(frame_err),
    .break_det(break_det), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (data_valid) begin
    n_valid++;
    valid_cyc = cyc;
    cap_d.push_back(data_out);
    cap_f.push_back(frame_err);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                            input logic stop_v, input int nstop);
    t0 = cyc;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    if (has_par) bit_time(pbit);
    for (int i = 0; i < nstop; i++) bit_time(stop_v);
    rx = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_brk", break_det, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 0;
    repeat (20) @(negedge clk);
    // 0xA5, no parity, one stop
    send_frame(8'hA5, 0, 0, 1, 1);
    repeat (10) @(negedge clk);
    chk("a5_count", n_valid, 1);
    chk("a5_latency", valid_cyc - t0, 155);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_perr", parity_err, 1'b0);
    chk("a5_ferr", frame_err, 1'b0);
    chk("a5_brk", break_det, 1'b0);
    chk("a5_busy", busy, 1'b0);
    // 0x3C has even weight: parity bit 1 is wrong for even, right for odd
    cfg_parity = 2'b01;
    send_frame(8'h3C, 1, 1, 1, 1);
    repeat (10) @(negedge clk);
    chk("even_count", n_valid, 2);
    chk("even_data", data_out, 8'h3C);
    chk("even_perr", parity_err, 1'b1);
    chk("even_ferr", frame_err, 1'b0);
    cfg_parity = 2'b10;
    send_frame(8'h3C, 1, 1, 1, 1);
    repeat (10) @(negedge clk);
    chk("odd_count", n_valid, 3);
    chk("odd_perr", parity_err, 1'b0);
    // 0x81 with low stop bit
    cfg_parity = 2'b00;
    send_frame(8'h81, 0, 0, 0, 1);
    repeat (20) @(negedge clk);
    chk("ferr_count", n_valid, 4);
    chk("ferr_data", data_out, 8'h81);
    chk("ferr_ferr", frame_err, 1'b1);
    chk("ferr_brk", break_det, 1'b0);
    // glitch: 5 clks low is rejected at the mid-start sample
    rx = 0;
    repeat (4) @(negedge clk);
    chk("glitch_busy_hi", busy, 1'b1);
    @(negedge clk);
    rx = 1;
    repeat (7) @(negedge clk);
    chk("glitch_busy_lo", busy, 1'b0);
    repeat (20) @(negedge clk);
    chk("glitch_count", n_valid, 4);
    chk("glitch_data", data_out, 8'h81);
    // break: line low for three frame times
    rx = 0;
    repeat (480) @(negedge clk);
    chk("brk_hold_count", n_valid, 5);
    rx = 1;
    repeat (40) @(negedge clk);
    chk("brk_count", n_valid, 5);
    chk("brk_data", data_out, 8'h00);
    chk("brk_ferr", frame_err, 1'b1);
    chk("brk_brk", break_det, 1'b1);
    chk("brk_perr", parity_err, 1'b0);
    // two stop bits, back-to-back frames
    cfg_stop2 = 1;
    nv0 = n_valid;
    send_frame(8'h11, 0, 0, 1, 2);
    send_frame(8'h22, 0, 0, 1, 2);
    repeat (10) @(negedge clk);
    chk("b2b_count", n_valid - nv0, 2);
    chk("b2b_d0", cap_d[nv0], 8'h11);
    chk("b2b_d1", cap_d[nv0 + 1], 8'h22);
    chk("b2b_f0", cap_f[nv0], 1'b0);
    chk("b2b_f1", cap_f[nv0 + 1], 1'b0);
    chk("b2b_brk", break_det, 1'b0);
    // reset during the data phase
    cfg_stop2 = 0;
    nv0 = n_valid;
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    bit_time(1'b1);
    chk("mid_busy_pre", busy, 1'b1);
    reset = 1;
    rx = 1;
    @(negedge clk);
    chk("mid_busy", busy, 1'b0);
    chk("mid_data", data_out, 8'h00);
    chk("mid_valid", data_valid, 1'b0);
    reset = 0;
    repeat (200) @(negedge clk);
    chk("mid_count", n_valid - nv0, 0);
    send_frame(8'h5A, 0, 0, 1, 1);
    repeat (10) @(negedge clk);
    chk("post_count", n_valid - nv0, 1);
    chk("post_data", data_out, 8'h5A);
    chk("post_ferr", frame_err, 1'b0);
    chk("post_perr", parity_err, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
